burst_host_driver: RTL and testbench
====================================

# burst_host_driver

Host-side command sequencer placed directly upstream of `Top`. It accepts burst write/read commands and write-data beats from a host, buffers write data in a FIFO, and drives `Top`'s `io_start`/`io_top_*` pins with the exact burst pattern `Top` expects. It also collects the returning `io_top_rdata` beats into a valid-qualified stream. It lets software-style traffic generators exercise the master/slave FSM pair without hand-timed stimulus.

## Interface
Parameters:
- `ADDR_W`, 4: address width; matches `io_top_address`.
- `LEN_W`, 4: burst-length width; length = number of beats.
- `DATA_W`, 32: data width.
- `WFIFO_DEPTH`, 16: write-data FIFO entries; must be ≥ 2^LEN_W − 1.
- `RD_LATENCY`, 2: cycles from the `io_top_rd` issue cycle to the first valid `io_top_rdata` beat.

Ports:
- `clock` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `io_cmd_valid` in 1; `io_cmd_ready` out 1: command handshake.
- `io_cmd_write` in 1: 1 = burst write, 0 = burst read.
- `io_cmd_address` in ADDR_W: burst start address.
- `io_cmd_length` in LEN_W: beat count.
- `io_wdat_valid` in 1; `io_wdat_ready` out 1; `io_wdat_bits` in DATA_W: write-data push.
- `io_rdat_valid` out 1; `io_rdat_bits` out DATA_W; `io_rdat_last` out 1: read-data stream, no backpressure.
- `io_busy` out 1: state ≠ IDLE.
- `io_start` out 1: to `Top`.
- `io_top_wr`, `io_top_rd` out 1: to `Top`.
- `io_top_address` out ADDR_W; `io_top_length` out LEN_W; `io_top_wdata` out DATA_W: to `Top`.
- `io_top_rdata` in DATA_W: from `Top`.

## Operation
- States: IDLE, WWAIT, WBURST, RWAIT, RBURST.
- `io_cmd_ready` = (state == IDLE). On accept, the command is latched.
  - Length 0: accepted and discarded; stays in IDLE, no bus activity.
  - Write: go to WWAIT.
  - Read: go to RWAIT and issue the read in the same transition (see Timing).
- WWAIT: hold until FIFO count ≥ latched length, then go to WBURST.
- WBURST, beat 0:
  - `io_top_wr` = 1, `io_top_address`/`io_top_length` = latched values, `io_top_wdata` = FIFO head; pop.
- WBURST, beats 1..len−1: `io_top_wr` = 0, address/length = 0, `io_top_wdata` = next FIFO head; pop each cycle. After the last beat, go to IDLE.
- RWAIT: count down RD_LATENCY−1 cycles after the issue cycle, then go to RBURST.
- RBURST: sample `io_top_rdata` for len consecutive cycles into a register.
  - Each sample is presented one cycle later with `io_rdat_valid` = 1.
  - `io_rdat_last` = 1 on the final beat.
  - After the final sample, go to IDLE.
- Write FIFO:
  - `io_wdat_ready` = (count < WFIFO_DEPTH), computed from count only; a push is refused when full even if a pop occurs in the same cycle.
  - Simultaneous push and pop (not full) leaves count unchanged.
  - Pushes are accepted in every state.
- `io_start` is registered: 0 during reset, 1 from the first cycle after reset deasserts.
- All `io_top_*` outputs are 0 in every cycle that is not an issue cycle or a data beat. No combinational path exists from any input to any `io_top_*` output.

## Timing
- Reset values:
  - All `io_top_*` outputs, `io_start`, `io_rdat_*` and `io_busy` = 0.
  - `io_cmd_ready` = 1 and `io_wdat_ready` = 1 from the cycle after reset.
  - FIFO empty; state IDLE.
- Reset asserted mid-burst abandons the burst: next cycle all outputs are at reset values and the FIFO is empty.
- Write: accept at cycle T with data already queued gives `io_top_wr` at T+1 and beats at T+1..T+len. `io_cmd_ready` returns at T+len+1.
- Read: accept at T gives `io_top_rd` at T+1.
  - Rdata is sampled at T+1+RD_LATENCY+k for k = 0..len−1.
  - `io_rdat_valid` is high at T+2+RD_LATENCY+k.
  - `io_cmd_ready` returns the cycle after the last sample.
- Length and count arithmetic is unsigned. FIFO pointers wrap modulo WFIFO_DEPTH; count is held in log2(WFIFO_DEPTH)+1 bits.

## Test plan
- **Reset:** hold `reset` 2 cycles → all `io_top_*`=0, `io_start`=0; after release `io_start`=1, `io_cmd_ready`=1, `io_wdat_ready`=1.
- **Burst write:** push 0xA,0xB,0xC,0xD, then cmd write addr 6 len 4 → one cycle with wr=1/addr=6/len=4/wdata=0xA, then wdata 0xB,0xC,0xD with wr=0/addr=0/len=0, then wdata=0 and `io_cmd_ready`=1.
- **Data starvation:** cmd write len 4 with 2 beats queued → no `io_top_wr`; push 2 more → `io_top_wr` the cycle after count reaches 4.
- **Burst read:** cmd read addr 6 len 4, RD_LATENCY 2, model returns 0x11..0x14 → rd=1/addr=6/len=4 for 1 cycle; `io_rdat_valid` for 4 cycles with 0x11..0x14; `io_rdat_last` only on 0x14.
- **FIFO full:** push 16 beats with no command → `io_wdat_ready`=0 after the 16th push; the 17th beat is not stored; cmd write len 15 drains 15 beats and `io_wdat_ready` returns high.
- **Reset mid-write:** reset after beat 2 of a len-4 write → next cycle `io_top_wdata`=0, `io_busy`=0, FIFO empty; a fresh len-1 write then completes normally.

Source files
------------

// File: rtl/burst_host_driver.sv
// Host-side burst sequencer: queues write data, replays burst commands onto the Top pin
// interface with registered outputs, and collects returning read beats into a valid stream.
module burst_host_driver #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WFIFO_DEPTH = 16,
    parameter int unsigned RD_LATENCY  = 2
) (
    input  logic              clock,
    input  logic              reset,
    // Command channel
    input  logic              io_cmd_valid,
    output logic              io_cmd_ready,
    input  logic              io_cmd_write,
    input  logic [ADDR_W-1:0] io_cmd_address,
    input  logic [LEN_W-1:0]  io_cmd_length,
    // Write-data push
    input  logic              io_wdat_valid,
    output logic              io_wdat_ready,
    input  logic [DATA_W-1:0] io_wdat_bits,
    // Read-data stream
    output logic              io_rdat_valid,
    output logic [DATA_W-1:0] io_rdat_bits,
    output logic              io_rdat_last,
    output logic              io_busy,
    // Top-facing pins
    output logic              io_start,
    output logic              io_top_wr,
    output logic              io_top_rd,
    output logic [ADDR_W-1:0] io_top_address,
    output logic [LEN_W-1:0]  io_top_length,
    output logic [DATA_W-1:0] io_top_wdata,
    input  logic [DATA_W-1:0] io_top_rdata
);

    localparam int unsigned PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(WFIFO_DEPTH) + 1;
    localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WWAIT  = 3'd1;
    localparam logic [2:0] WBURST = 3'd2;
    localparam logic [2:0] RWAIT  = 3'd3;
    localparam logic [2:0] RBURST = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  left_q, left_d;
    logic [LAT_W-1:0]  wait_q, wait_d;

    logic [DATA_W-1:0] mem [WFIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    logic              start_q;
    logic              top_wr_q, top_wr_d;
    logic              top_rd_q, top_rd_d;
    logic [ADDR_W-1:0] top_addr_q, top_addr_d;
    logic [LEN_W-1:0]  top_len_q, top_len_d;
    logic [DATA_W-1:0] top_wdata_q, top_wdata_d;
    logic              rdat_valid_q, rdat_valid_d;
    logic [DATA_W-1:0] rdat_bits_q, rdat_bits_d;
    logic              rdat_last_q, rdat_last_d;

    logic              launch;
    logic [ADDR_W-1:0] launch_addr;
    logic [LEN_W-1:0]  launch_len;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WFIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic fifo_holds(input logic [CNT_W-1:0] cnt, input logic [LEN_W-1:0] n);
        return 32'(cnt) >= 32'(n);
    endfunction

    assign io_wdat_ready = (count_q < CNT_W'(WFIFO_DEPTH));
    assign push          = io_wdat_valid && io_wdat_ready;

    // All Top-facing pins are next-state registers; every cycle defaults them back to zero.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        left_d       = left_q;
        wait_d       = wait_q;
        pop          = 1'b0;
        top_wr_d     = 1'b0;
        top_rd_d     = 1'b0;
        top_addr_d   = '0;
        top_len_d    = '0;
        top_wdata_d  = '0;
        rdat_valid_d = 1'b0;
        rdat_bits_d  = rdat_bits_q;
        rdat_last_d  = 1'b0;
        launch       = 1'b0;
        launch_addr  = addr_q;
        launch_len   = len_q;

        case (state_q)
            IDLE: begin
                if (io_cmd_valid && (io_cmd_length != '0)) begin
                    addr_d = io_cmd_address;
                    len_d  = io_cmd_length;
                    if (io_cmd_write) begin
                        if (fifo_holds(count_q, io_cmd_length)) begin
                            launch      = 1'b1;
                            launch_addr = io_cmd_address;
                            launch_len  = io_cmd_length;
                        end else begin
                            state_d = WWAIT;
                        end
                    end else begin
                        top_rd_d   = 1'b1;
                        top_addr_d = io_cmd_address;
                        top_len_d  = io_cmd_length;
                        left_d     = io_cmd_length - LEN_W'(1);
                        wait_d     = LAT_W'(RD_LATENCY - 1);
                        state_d    = RWAIT;
                    end
                end
            end
            WWAIT: begin
                if (fifo_holds(count_q, len_q)) begin
                    launch = 1'b1;
                end
            end
            WBURST: begin
                if (left_q != '0) begin
                    top_wdata_d = mem[rd_ptr_q];
                    pop         = 1'b1;
                    left_d      = left_q - LEN_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            RWAIT: begin
                if (wait_q == '0) begin
                    state_d = RBURST;
                end else begin
                    wait_d = wait_q - LAT_W'(1);
                end
            end
            RBURST: begin
                rdat_valid_d = 1'b1;
                rdat_bits_d  = io_top_rdata;
                rdat_last_d  = (left_q == '0);
                if (left_q == '0) begin
                    state_d = IDLE;
                end else begin
                    left_d = left_q - LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Beat 0 is loaded on the same edge that pops the FIFO head it carries.
        if (launch) begin
            top_wr_d    = 1'b1;
            top_addr_d  = launch_addr;
            top_len_d   = launch_len;
            top_wdata_d = mem[rd_ptr_q];
            pop         = 1'b1;
            left_d      = launch_len - LEN_W'(1);
            state_d     = WBURST;
        end
    end

    always_comb begin
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= io_wdat_bits;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            left_q       <= '0;
            wait_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            start_q      <= 1'b0;
            top_wr_q     <= 1'b0;
            top_rd_q     <= 1'b0;
            top_addr_q   <= '0;
            top_len_q    <= '0;
            top_wdata_q  <= '0;
            rdat_valid_q <= 1'b0;
            rdat_bits_q  <= '0;
            rdat_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            left_q       <= left_d;
            wait_q       <= wait_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            start_q      <= 1'b1;
            top_wr_q     <= top_wr_d;
            top_rd_q     <= top_rd_d;
            top_addr_q   <= top_addr_d;
            top_len_q    <= top_len_d;
            top_wdata_q  <= top_wdata_d;
            rdat_valid_q <= rdat_valid_d;
            rdat_bits_q  <= rdat_bits_d;
            rdat_last_q  <= rdat_last_d;
        end
    end

    assign io_cmd_ready   = (state_q == IDLE);
    assign io_busy        = (state_q != IDLE);
    assign io_start       = start_q;
    assign io_top_wr      = top_wr_q;
    assign io_top_rd      = top_rd_q;
    assign io_top_address = top_addr_q;
    assign io_top_length  = top_len_q;
    assign io_top_wdata   = top_wdata_q;
    assign io_rdat_valid  = rdat_valid_q;
    assign io_rdat_bits   = rdat_bits_q;
    assign io_rdat_last   = rdat_last_q;

endmodule

// File: tb/tb_burst_host_driver.sv
// Bench for burst_host_driver: directed and random burst traffic checked against a
// transaction-level model (FIFO contents as a queue, burst timing from cycle arithmetic).
module tb_burst_host_driver;

    localparam int ADDR_W = 4;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int RDL    = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              io_cmd_valid = 1'b0;
    logic              io_cmd_ready;
    logic              io_cmd_write = 1'b0;
    logic [ADDR_W-1:0] io_cmd_address = '0;
    logic [LEN_W-1:0]  io_cmd_length = '0;
    logic              io_wdat_valid = 1'b0;
    logic              io_wdat_ready;
    logic [DATA_W-1:0] io_wdat_bits = '0;
    logic              io_rdat_valid;
    logic [DATA_W-1:0] io_rdat_bits;
    logic              io_rdat_last;
    logic              io_busy;
    logic              io_start;
    logic              io_top_wr;
    logic              io_top_rd;
    logic [ADDR_W-1:0] io_top_address;
    logic [LEN_W-1:0]  io_top_length;
    logic [DATA_W-1:0] io_top_wdata;
    logic [DATA_W-1:0] io_top_rdata = '0;

    always #5 clock = ~clock;

    burst_host_driver #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W),
        .WFIFO_DEPTH(DEPTH), .RD_LATENCY(RDL)
    ) dut (
        .clock(clock), .reset(reset),
        .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
        .io_cmd_write(io_cmd_write), .io_cmd_address(io_cmd_address),
        .io_cmd_length(io_cmd_length),
        .io_wdat_valid(io_wdat_valid), .io_wdat_ready(io_wdat_ready),
        .io_wdat_bits(io_wdat_bits),
        .io_rdat_valid(io_rdat_valid), .io_rdat_bits(io_rdat_bits),
        .io_rdat_last(io_rdat_last), .io_busy(io_busy), .io_start(io_start),
        .io_top_wr(io_top_wr), .io_top_rd(io_top_rd),
        .io_top_address(io_top_address), .io_top_length(io_top_length),
        .io_top_wdata(io_top_wdata), .io_top_rdata(io_top_rdata)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ovr_lo = -100;
    logic [31:0] q[$];
    bit          pend_push = 0;
    logic [31:0] pend_data = '0;

    // Read data Top returns in cycle c; a 4-cycle window can be forced to 0x11..0x14.
    function automatic logic [31:0] rdat_at(input int c);
        if (c >= ovr_lo && c < ovr_lo + 4) return 32'h11 + 32'(c - ovr_lo);
        return (32'(c) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (pend_push) q.push_back(pend_data);
        pend_push     = 0;
        io_cmd_valid  = 1'b0;
        io_wdat_valid = 1'b0;
        io_top_rdata  = rdat_at(cyc);
    endtask

    task automatic maybe_push(input int pct);
        logic [31:0] d;
        chk("wdat_ready", 32'(io_wdat_ready), 32'(q.size() < DEPTH));
        if (int'($urandom_range(99)) < pct) begin
            d             = $urandom;
            io_wdat_valid = 1'b1;
            io_wdat_bits  = d;
            if (q.size() < DEPTH) begin
                pend_push = 1;
                pend_data = d;
            end
        end
    endtask

    task automatic chk_quiet();
        chk("top_wr_idle", 32'(io_top_wr), 0);
        chk("top_rd_idle", 32'(io_top_rd), 0);
        chk("top_addr_idle", 32'(io_top_address), 0);
        chk("top_len_idle", 32'(io_top_length), 0);
        chk("top_wdata_idle", io_top_wdata, 0);
    endtask

    task automatic chk_ctl(input bit busy);
        chk("busy", 32'(io_busy), 32'(busy));
        chk("cmd_ready", 32'(io_cmd_ready), 32'(!busy));
        chk("start", 32'(io_start), 1);
    endtask

    task automatic do_reset(input int n);
        reset         = 1'b1;
        io_cmd_valid  = 1'b0;
        io_wdat_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk_quiet();
            chk("start_rst", 32'(io_start), 0);
            chk("busy_rst", 32'(io_busy), 0);
            chk("rdat_valid_rst", 32'(io_rdat_valid), 0);
        end
        reset = 1'b0;
        q.delete();
        pend_push = 0;
        tick();
        chk_ctl(0);
        chk("wdat_ready_after_rst", 32'(io_wdat_ready), 1);
        chk_quiet();
    endtask

    task automatic issue(input bit wr, input int addr, input int len);
        chk_ctl(0);
        io_cmd_valid   = 1'b1;
        io_cmd_write   = wr;
        io_cmd_address = 4'(addr);
        io_cmd_length  = 4'(len);
    endtask

    task automatic do_write(input int addr, input int len, input int pct);
        bit          go;
        int          waited;
        logic [31:0] exp;
        issue(1'b1, addr, len);
        go = (q.size() >= len);
        maybe_push(pct);
        if (len == 0) begin
            tick();
            chk_ctl(0);
            chk_quiet();
            return;
        end
        waited = 0;
        while (!go) begin
            tick();
            chk_ctl(1);
            chk_quiet();
            go = (q.size() >= len);
            maybe_push(pct < 40 ? 40 : pct);
            waited++;
            if (waited > 300) begin
                total++;
                bad++;
                $error("FAIL write_wait_bound: observed=%0d cycles expected=<=300", waited);
                return;
            end
        end
        for (int k = 0; k < len; k++) begin
            tick();
            exp = q.pop_front();
            chk("top_wr", 32'(io_top_wr), 32'(k == 0));
            chk("top_rd_w", 32'(io_top_rd), 0);
            chk("top_addr_w", 32'(io_top_address), (k == 0) ? 32'(addr) : 0);
            chk("top_len_w", 32'(io_top_length), (k == 0) ? 32'(len) : 0);
            chk("top_wdata", io_top_wdata, exp);
            chk("rdat_valid_w", 32'(io_rdat_valid), 0);
            chk_ctl(1);
            maybe_push(pct);
        end
        tick();
        chk_ctl(0);
        chk_quiet();
        chk("rdat_valid_w_end", 32'(io_rdat_valid), 0);
    endtask

    task automatic do_read(input int addr, input int len, input int pct);
        int t0;
        int k;
        bit v;
        issue(1'b0, addr, len);
        t0 = cyc;
        maybe_push(pct);
        tick();
        if (len == 0) begin
            chk_ctl(0);
            chk_quiet();
            return;
        end
        chk("top_rd", 32'(io_top_rd), 1);
        chk("top_wr_r", 32'(io_top_wr), 0);
        chk("top_addr_r", 32'(io_top_address), 32'(addr));
        chk("top_len_r", 32'(io_top_length), 32'(len));
        chk("top_wdata_r", io_top_wdata, 0);
        chk("rdat_valid_issue", 32'(io_rdat_valid), 0);
        chk_ctl(1);
        maybe_push(pct);
        for (int c = t0 + 2; c <= t0 + 1 + RDL + len; c++) begin
            tick();
            chk_quiet();
            chk_ctl(c <= t0 + RDL + len);
            v = (c >= t0 + 2 + RDL);
            chk("rdat_valid", 32'(io_rdat_valid), 32'(v));
            if (v) begin
                k = c - (t0 + 2 + RDL);
                chk("rdat_bits", io_rdat_bits, rdat_at(c - 1));
                chk("rdat_last", 32'(io_rdat_last), 32'(k == len - 1));
            end else begin
                chk("rdat_last_idle", 32'(io_rdat_last), 0);
            end
            maybe_push(pct);
        end
    endtask

    task automatic push_val(input logic [31:0] d);
        chk("wdat_ready_push", 32'(io_wdat_ready), 32'(q.size() < DEPTH));
        io_wdat_valid = 1'b1;
        io_wdat_bits  = d;
        if (q.size() < DEPTH) begin
            pend_push = 1;
            pend_data = d;
        end
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // Reset held two cycles
        do_reset(2);

        // Directed burst write
        push_val(32'hA);
        push_val(32'hB);
        push_val(32'hC);
        push_val(32'hD);
        do_write(6, 4, 0);

        // Data starvation: two beats queued for a four-beat write
        push_val(32'h21);
        push_val(32'h22);
        do_write(2, 4, 0);

        // Directed burst read with Top returning 0x11..0x14
        ovr_lo = cyc + 1 + RDL;
        do_read(6, 4, 0);

        // FIFO full: 17th push refused, then drain
        for (int i = 0; i < 17; i++) begin
            maybe_push(100);
            tick();
        end
        chk("wdat_ready_full", 32'(io_wdat_ready), 0);
        do_write(1, 15, 0);
        chk("wdat_ready_drained", 32'(io_wdat_ready), 1);
        do_write(9, 1, 0);

        // Reset abandoning a write after beat 2
        for (int i = 0; i < 4; i++) push_val($urandom);
        issue(1'b1, 3, 4);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_wdata", io_top_wdata, q.pop_front());
        end
        do_reset(1);
        chk("mid_busy", 32'(io_busy), 0);
        do_write(5, 1, 0);

        // Random mixed traffic
        for (int i = 0; i < 40; i++) begin
            int a;
            int l;
            int p;
            a = $urandom_range(15);
            l = $urandom_range(15);
            p = $urandom_range(70);
            if ($urandom_range(1) == 1) do_write(a, l, p);
            else do_read(a, l, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
